// File: rtl/pwm_pkg.sv
// Shared PWM constants and capture state encoding. The generator imports
// the same package so the two ends cannot disagree on the frame length.
package pwm_pkg;
    localparam int PWM_PERIOD   = 255;
    localparam int PWM_SAMPLE_W = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } cap_state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// Control/data bundle between a PWM source/consumer and the capture block.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_SAMPLE_W
);
    logic             en;
    logic             pwm_in;
    logic [WIDTH-1:0] sample_out;
    logic             sample_valid;
    logic             locked;
    logic             lock_err;

    modport master (
        output en, pwm_in,
        input  sample_out, sample_valid, locked, lock_err
    );

    modport slave (
        input  en, pwm_in,
        output sample_out, sample_valid, locked, lock_err
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer for a single asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Both stages clear together so no stale level survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// PWM demodulator: locks to the frame start on a rising edge, counts high
// slots over PERIOD clocks and emits one WIDTH-bit sample per frame.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int WIDTH  = PWM_SAMPLE_W
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.slave  bus
);
    // PERIOD <= 2^WIDTH-1, so the slot index and the high count both fit.
    localparam logic [WIDTH-1:0] LAST_SLOT = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    cap_state_t       state;
    logic [WIDTH-1:0] fc;
    logic [WIDTH-1:0] hc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pwm_in),
        .q   (pwm_s)
    );

    // One-cycle delay of the synchronized level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) pwm_d <= 1'b0;
        else     pwm_d <= pwm_s;
    end

    assign rise = pwm_s & ~pwm_d;

    // Lock FSM, slot/high counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HUNT;
            fc               <= '0;
            hc               <= '0;
            bus.sample_out   <= '0;
            bus.sample_valid <= 1'b0;
            bus.locked       <= 1'b0;
            bus.lock_err     <= 1'b0;
        end else begin
            bus.sample_valid <= 1'b0;
            bus.lock_err     <= 1'b0;
            if (!bus.en) begin
                // Drop any partial frame; sample_out keeps its last value.
                state      <= HUNT;
                bus.locked <= 1'b0;
                fc         <= '0;
                hc         <= '0;
            end else begin
                case (state)
                    HUNT: begin
                        if (rise) begin
                            // The edge cycle itself is slot 0 and is high.
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                            fc         <= ONE;
                            hc         <= ONE;
                        end
                    end
                    LOCKED: begin
                        if (rise && fc != '0) begin
                            // Edge out of place: realign here, discard frame,
                            // even if this was the last slot.
                            bus.lock_err <= 1'b1;
                            fc           <= ONE;
                            hc           <= ONE;
                        end else if (fc == LAST_SLOT) begin
                            bus.sample_out   <= hc + WIDTH'(pwm_s);
                            bus.sample_valid <= 1'b1;
                            fc               <= '0;
                            hc               <= '0;
                        end else begin
                            hc <= hc + WIDTH'(pwm_s);
                            fc <= fc + ONE;
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
